// File: rtl/alu_pkg.sv
// Shared types for the ALU result checker: operation encoding and the
// run-control state machine encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CMP_LAST,
        ST_DONE
    } checker_state_t;

    // Depth of the optional mismatch log FIFO.
    localparam int LOG_DEPTH = 4;
    localparam int LOG_PTR_W = $clog2(LOG_DEPTH);

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference ALU: produces the expected result for one sample.
// Carries and borrows are dropped, so ADD/SUB wrap modulo 2^WIDTH.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  alu_op_t            op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   y
);

    // Select the expected result by operation.
    always_comb begin
        y = '0;
        unique case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_result_checker.sv
// ALU result checker: accepts (op, a, b, y) samples during a run, compares
// each against a reference model one cycle after acceptance, and keeps
// saturating pass/fail counts plus the first mismatch location.
// Optional feature macro ALU_CHECKER_LOG_EN adds a 4-deep FIFO of
// {idx, op} for mismatching samples with a pop interface.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [1:0]       s_op,
    input  logic [WIDTH-1:0] s_a,
    input  logic [WIDTH-1:0] s_b,
    input  logic [WIDTH-1:0] s_y,
    input  logic             s_last,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_exp
`ifdef ALU_CHECKER_LOG_EN
    ,
    input  logic             err_rd_en,
    output logic             err_valid,
    output logic [CNT_W-1:0] err_idx,
    output logic [1:0]       err_op
`endif
);

    typedef struct packed {
        alu_op_t          op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] y;
        logic [CNT_W-1:0] idx;
    } smp_t;

    checker_state_t   state, state_nxt;
    smp_t             smp_q;
    logic             cmp_vld;
    logic [CNT_W-1:0] idx_cnt;
    logic [WIDTH-1:0] exp_y;
    logic             acc, clr, mismatch;

    assign acc      = s_valid && s_ready;
    assign clr      = (state == ST_IDLE) && start;
    assign mismatch = cmp_vld && (exp_y != smp_q.y);
    assign pass     = (fail_cnt == '0);

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .op (smp_q.op),
        .a  (smp_q.a),
        .b  (smp_q.b),
        .y  (exp_y)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and run-control outputs.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE:     if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (acc && s_last) state_nxt = ST_CMP_LAST;
            end
            ST_CMP_LAST: begin
                busy      = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Sample capture, one-cycle-later compare, and result counters.
    // Reset also drops any captured-but-uncompared sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q          <= '0;
            cmp_vld        <= 1'b0;
            idx_cnt        <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
        end else if (clr) begin
            cmp_vld        <= 1'b0;
            idx_cnt        <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
        end else begin
            cmp_vld <= acc;
            if (acc) begin
                smp_q   <= '{op: alu_op_t'(s_op), a: s_a, b: s_b, y: s_y, idx: idx_cnt};
                idx_cnt <= idx_cnt + 1'b1;
            end
            if (cmp_vld) begin
                if (!mismatch) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    // fail_cnt saturates and never returns to 0 within a run,
                    // so zero marks the first mismatch.
                    if (fail_cnt == '0) begin
                        first_fail_idx <= smp_q.idx;
                        first_fail_exp <= exp_y;
                    end
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                end
            end
        end
    end

`ifdef ALU_CHECKER_LOG_EN
    logic [CNT_W+1:0]     log_mem [LOG_DEPTH];
    logic [LOG_PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LOG_PTR_W:0]   log_cnt;
    logic                 push, pop, full;

    assign full      = (log_cnt == LOG_PTR_W'(0) + (LOG_PTR_W+1)'(LOG_DEPTH));
    assign err_valid = (log_cnt != '0);
    assign pop       = err_rd_en && err_valid;
    // A full FIFO still accepts a push when a pop frees a slot the same cycle.
    assign push      = mismatch && (!full || pop);
    assign err_idx   = log_mem[rd_ptr][CNT_W+1:2];
    assign err_op    = log_mem[rd_ptr][1:0];

    // Log storage write.
    always_ff @(posedge clk) begin
        if (push) log_mem[wr_ptr] <= {smp_q.idx, smp_q.op};
    end

    // Log pointers and occupancy; cleared with the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            log_cnt <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            log_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      log_cnt <= log_cnt + 1'b1;
            else if (pop && !push) log_cnt <= log_cnt - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed self-checking bench for alu_result_checker (WIDTH=3, CNT_W=16).
module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        rst_n, start, s_valid, s_ready, s_last;
    logic [1:0]  s_op;
    logic [2:0]  s_a, s_b, s_y;
    logic        busy, done, pass;
    logic [15:0] pass_cnt, fail_cnt, first_fail_idx;
    logic [2:0]  first_fail_exp;
`ifdef ALU_CHECKER_LOG_EN
    logic        err_rd_en, err_valid;
    logic [15:0] err_idx;
    logic [1:0]  err_op;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_result_checker #(.WIDTH(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid),
        .s_ready(s_ready), .s_op(s_op), .s_a(s_a), .s_b(s_b), .s_y(s_y),
        .s_last(s_last), .busy(busy), .done(done), .pass(pass),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp)
`ifdef ALU_CHECKER_LOG_EN
        , .err_rd_en(err_rd_en), .err_valid(err_valid),
        .err_idx(err_idx), .err_op(err_op)
`endif
    );

    // Pulse start for one cycle; returns 1 time unit after the edge entering RUN.
    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Offer one sample and hold it until accepted (bounded).
    task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] y, input logic last);
        bit got = 1'b0;
        s_valid = 1'b1; s_op = op; s_a = a; s_b = b; s_y = y; s_last = last;
        for (int i = 0; i < 20 && !got; i++) begin
            got = s_ready;
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL send_accept: sample not accepted within 20 cycles");
        end
    endtask

    // Wait (bounded) until done is high; leaves time inside the DONE cycle.
    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_done: done=0, required 1 within 10 cycles", name);
        end
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if ({s_ready, busy, done, pass} !== 4'b0001) begin
            fails++;
            $display("FAIL reset_ctl: rdy/busy/done/pass=%b, required 0001", {s_ready, busy, done, pass});
        end
        tests++;
        if ({pass_cnt, fail_cnt, first_fail_idx, first_fail_exp} !== '0) begin
            fails++;
            $display("FAIL reset_cnt: pass=%0d fail=%0d ffi=%0d ffe=%0d, required all 0",
                     pass_cnt, fail_cnt, first_fail_idx, first_fail_exp);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_or_pass();
        do_start();
        tests++;
        if (s_ready !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL or_pass_run: s_ready=%b busy=%b, required 1 1", s_ready, busy);
        end
        send(2'b01, 3'b101, 3'b010, 3'b111, 1'b0);
        send(2'b01, 3'b010, 3'b111, 3'b111, 1'b1);
        wait_done("or_pass");
        tests++;
        if (pass !== 1'b1 || pass_cnt !== 16'd2 || fail_cnt !== 16'd0) begin
            fails++;
            $display("FAIL or_pass_res: pass=%b pc=%0d fc=%0d, required 1 2 0", pass, pass_cnt, fail_cnt);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL or_pass_pulse: done=%b busy=%b after DONE, required 0 0", done, busy);
        end
    endtask

    task automatic test_or_fail();
        do_start();
        send(2'b01, 3'b101, 3'b010, 3'b111, 1'b0);
        send(2'b01, 3'b000, 3'b111, 3'b011, 1'b1);
        wait_done("or_fail");
        tests++;
        if (fail_cnt !== 16'd1 || pass_cnt !== 16'd1 || pass !== 1'b0) begin
            fails++;
            $display("FAIL or_fail_cnt: fc=%0d pc=%0d pass=%b, required 1 1 0", fail_cnt, pass_cnt, pass);
        end
        tests++;
        if (first_fail_idx !== 16'd1 || first_fail_exp !== 3'b111) begin
            fails++;
            $display("FAIL or_fail_first: idx=%0d exp=%b, required 1 111", first_fail_idx, first_fail_exp);
        end
    endtask

    task automatic test_wrap();
        do_start();
        send(2'b10, 3'b111, 3'b001, 3'b000, 1'b0);
        send(2'b11, 3'b000, 3'b001, 3'b111, 1'b1);
        wait_done("wrap");
        tests++;
        if (pass_cnt !== 16'd2 || fail_cnt !== 16'd0 || first_fail_idx !== 16'd0) begin
            fails++;
            $display("FAIL wrap_res: pc=%0d fc=%0d ffi=%0d, required 2 0 0", pass_cnt, fail_cnt, first_fail_idx);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] op_t [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
        logic [2:0] a_t  [8] = '{3'b110, 3'b100, 3'b011, 3'b010, 3'b111, 3'b000, 3'b100, 3'b111};
        logic [2:0] b_t  [8] = '{3'b011, 3'b001, 3'b010, 3'b011, 3'b101, 3'b000, 3'b100, 3'b010};
        logic [2:0] y_t  [8] = '{3'b010, 3'b101, 3'b101, 3'b111, 3'b101, 3'b000, 3'b000, 3'b101};
        int not_ready = 0;
        do_start();
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_op = op_t[i]; s_a = a_t[i]; s_b = b_t[i]; s_y = y_t[i]; s_last = (i == 7);
            if (s_ready !== 1'b1) not_ready++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        tests++;
        if (not_ready != 0) begin
            fails++;
            $display("FAIL b2b_ready: %0d of 8 cycles not ready, required 0", not_ready);
        end
        tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_cmp_last: done=%b busy=%b, required 0 1", done, busy);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done_lat: done=%b two cycles after last accept, required 1", done);
        end
        tests++;
        if (pass_cnt !== 16'd8 || fail_cnt !== 16'd0) begin
            fails++;
            $display("FAIL b2b_cnt: pc=%0d fc=%0d, required 8 0", pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int done_seen = 0;
        do_start();
        send(2'b00, 3'b111, 3'b111, 3'b111, 1'b0);
        send(2'b00, 3'b111, 3'b111, 3'b000, 1'b0);
        send(2'b00, 3'b111, 3'b111, 3'b111, 1'b0);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({s_ready, busy, done, pass} !== 4'b0001 || pass_cnt !== 16'd0 ||
            fail_cnt !== 16'd0 || first_fail_idx !== 16'd0) begin
            fails++;
            $display("FAIL midrst_vals: rdy/busy/done/pass=%b pc=%0d fc=%0d ffi=%0d, required 0001 0 0 0",
                     {s_ready, busy, done, pass}, pass_cnt, fail_cnt, first_fail_idx);
        end
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        tests++;
        if (done_seen != 0 || fail_cnt !== 16'd0) begin
            fails++;
            $display("FAIL midrst_nodone: done cycles=%0d fc=%0d, required 0 0", done_seen, fail_cnt);
        end
        do_start();
        send(2'b10, 3'b011, 3'b011, 3'b110, 1'b1);
        wait_done("midrst_rerun");
        tests++;
        if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || pass !== 1'b1) begin
            fails++;
            $display("FAIL midrst_rerun: pc=%0d fc=%0d pass=%b, required 1 0 1", pass_cnt, fail_cnt, pass);
        end
    endtask

`ifdef ALU_CHECKER_LOG_EN
    task automatic test_log();
        do_start();
        for (int i = 0; i < 6; i++) send(2'b00, 3'b111, 3'b111, 3'b000, i == 5);
        wait_done("log");
        tests++;
        if (fail_cnt !== 16'd6 || err_valid !== 1'b1) begin
            fails++;
            $display("FAIL log_fill: fc=%0d err_valid=%b, required 6 1", fail_cnt, err_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (err_valid !== 1'b1 || err_idx !== 16'(i) || err_op !== 2'b00) begin
                fails++;
                $display("FAIL log_pop%0d: valid=%b idx=%0d op=%b, required 1 %0d 00",
                         i, err_valid, err_idx, err_op, i);
            end
            err_rd_en = 1'b1;
            @(posedge clk); #1 err_rd_en = 1'b0;
        end
        tests++;
        if (err_valid !== 1'b0) begin
            fails++;
            $display("FAIL log_empty: err_valid=%b, required 0", err_valid);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        s_op = '0; s_a = '0; s_b = '0; s_y = '0;
`ifdef ALU_CHECKER_LOG_EN
        err_rd_en = 1'b0;
`endif
        test_reset();
        test_or_pass();
        test_or_fail();
        test_wrap();
        test_back_to_back();
        test_reset_mid_run();
`ifdef ALU_CHECKER_LOG_EN
        test_log();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
